// File: rtl/bid_arb_pkg.sv
// Shared types and helpers for the bidding arbiter: FSM state encoding,
// default widths and the bid eligibility rule.
package bid_arb_pkg;

    localparam int BID_W_DEF = 4;
    localparam int BAL_W_DEF = 10;

    typedef enum logic [2:0] {IDLE, SNAP, SCAN, CHARGE, HOLD} arb_state_t;

    // The bank floors at 1, so a bid equal to the balance cannot be paid.
    function automatic logic eligible(input logic r, input logic [31:0] b, input logic [31:0] bal);
        return r && (b != 32'd0) && (bal > b);
    endfunction

endpackage

// File: rtl/bid_arbiter_scan.sv
// Snapshot registers plus a one-requester-per-cycle best-bid scanner (module bid_scan).
// best_* outputs already include the requester being examined this cycle.
module bid_scan
    import bid_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int BID_W = BID_W_DEF,
    parameter int BAL_W = BAL_W_DEF,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [IDX_W-1:0]   start,
    input  logic [N-1:0]       req,
    input  logic [N*BID_W-1:0] bid,
    input  logic [N*BAL_W-1:0] balance,
    output logic               done,
    output logic               best_valid,
    output logic [IDX_W-1:0]   best_idx,
    output logic [BID_W-1:0]   best_bid
);

    logic [N-1:0]       req_s;
    logic [N*BID_W-1:0] bid_s;
    logic [N*BAL_W-1:0] bal_s;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   cnt;
    logic               cur_valid;
    logic [IDX_W-1:0]   cur_idx;
    logic [BID_W-1:0]   cur_bid;
    logic [BID_W-1:0]   cand_bid;
    logic [BAL_W-1:0]   cand_bal;
    logic               take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            cur_valid <= 1'b0;
        end else if (load) begin
            idx       <= start;
            cnt       <= '0;
            cur_valid <= 1'b0;
        end else if (step) begin
            idx       <= (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
            cnt       <= cnt + IDX_W'(1);
            cur_valid <= best_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            req_s   <= req;
            bid_s   <= bid;
            bal_s   <= balance;
            cur_idx <= '0;
            cur_bid <= '0;
        end else if (step) begin
            cur_idx <= best_idx;
            cur_bid <= best_bid;
        end
    end

    // Strict '>' keeps the earlier-scanned requester on equal bids.
    always_comb begin
        cand_bid   = bid_s[int'(idx)*BID_W +: BID_W];
        cand_bal   = bal_s[int'(idx)*BAL_W +: BAL_W];
        take       = eligible(req_s[idx], 32'(cand_bid), 32'(cand_bal)) &&
                     (!cur_valid || (cand_bid > cur_bid));
        best_valid = cur_valid | take;
        best_idx   = take ? idx : cur_idx;
        best_bid   = take ? cand_bid : cur_bid;
    end

    assign done = step && (cnt == IDX_W'(N - 1));

endmodule

// File: rtl/bid_arbiter.sv
// Bidding bus arbiter: snapshot, sequential scan, one-cycle charge, bounded hold.
// Optional BID_ARB_RR_EN: scan starts at a round-robin pointer for fair ties.
module bid_arbiter
    import bid_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int BID_W  = BID_W_DEF,
    parameter int BAL_W  = BAL_W_DEF,
    parameter int TENURE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*BID_W-1:0] bid,
    input  logic [N*BAL_W-1:0] balance,
    input  logic [N-1:0]       rel,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       charge,
    output logic [BID_W-1:0]   win_bid,
    output logic               busy,
    output logic               nobid
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(TENURE + 1);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  ten_cnt;
    logic              scan_done;
    logic              best_valid;
    logic [IDX_W-1:0]  best_idx;
    logic [BID_W-1:0]  best_bid;
    logic              tenure_end;

    bid_scan #(.N(N), .BID_W(BID_W), .BAL_W(BAL_W)) u_scan (
        .clk        (clk),
        .rst        (rst),
        .load       (state == SNAP),
        .step       (state == SCAN),
        .start      (rr_ptr),
        .req        (req),
        .bid        (bid),
        .balance    (balance),
        .done       (scan_done),
        .best_valid (best_valid),
        .best_idx   (best_idx),
        .best_bid   (best_bid)
    );

    // ten_cnt counts grant cycles still to come after the current one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = SNAP;
            SNAP:    state_nxt = SCAN;
            SCAN:    if (scan_done) state_nxt = best_valid ? CHARGE : IDLE;
            CHARGE:  state_nxt = (ten_cnt == '0) ? IDLE : HOLD;
            HOLD:    if (rel[win] || !req[win] || ten_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        tenure_end = (state == CHARGE || state == HOLD) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win     <= '0;
            ten_cnt <= '0;
            gnt     <= '0;
            charge  <= '0;
            win_bid <= '0;
            busy    <= 1'b0;
            nobid   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != IDLE);
            nobid  <= (state == SCAN) && scan_done && !best_valid;
            charge <= (state_nxt == CHARGE) ? (N'(1) << best_idx) : '0;
            if (state_nxt == CHARGE) begin
                win     <= best_idx;
                win_bid <= best_bid;
                ten_cnt <= CNT_W'(TENURE - 1);
                gnt     <= N'(1) << best_idx;
            end else if (state_nxt == HOLD) begin
                ten_cnt <= ten_cnt - CNT_W'(1);
            end else begin
                gnt <= '0;
            end
        end
    end

`ifdef BID_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (tenure_end)
            rr_ptr <= (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_bid_arbiter.sv
// Directed and randomized bench for bid_arbiter with a behavioural bank and
// a reference winner model computed from the bidding rules.
module tb_bid_arbiter;

    localparam int N      = 4;
    localparam int BID_W  = 4;
    localparam int BAL_W  = 10;
    localparam int TENURE = 16;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*BID_W-1:0] bid;
    logic [N*BAL_W-1:0] balance;
    logic [N-1:0]       rel;
    logic [N-1:0]       gnt;
    logic [N-1:0]       charge;
    logic [BID_W-1:0]   win_bid;
    logic               busy;
    logic               nobid;

    int bid_v    [N];
    int bank_bal [N];
    int checks      = 0;
    int failures    = 0;
    int charges     = 0;
    int exp_charges = 0;
    int rr_exp      = 0;

    bid_arbiter #(.N(N), .BID_W(BID_W), .BAL_W(BAL_W), .TENURE(TENURE)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .bid     (bid),
        .balance (balance),
        .rel     (rel),
        .gnt     (gnt),
        .charge  (charge),
        .win_bid (win_bid),
        .busy    (busy),
        .nobid   (nobid)
    );

    always #5 clk = ~clk;

    always_comb begin
        bid     = '0;
        balance = '0;
        for (int i = 0; i < N; i++) begin
            bid[i*BID_W +: BID_W]     = bid_v[i][BID_W-1:0];
            balance[i*BAL_W +: BAL_W] = bank_bal[i][BAL_W-1:0];
        end
    end

    // Bank model: deducts the bid on each negedge where its charge line is high.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (charge[i]) begin
                charges++;
                bank_bal[i] = (bank_bal[i] - bid_v[i] < 1) ? 1 : bank_bal[i] - bid_v[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Winner by the rules: highest eligible bid, first in scan order on ties.
    function automatic int pick(input logic [N-1:0] r, input int start);
        int best = -1;
        int bb   = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i] && bid_v[i] != 0 && bank_bal[i] > bid_v[i] && (best < 0 || bid_v[i] > bb)) begin
                best = i;
                bb   = bid_v[i];
            end
        end
        return best;
    endfunction

    task automatic set_all(input int b0, input int b1, input int b2, input int b3,
                           input int a0, input int a1, input int a2, input int a3);
        @(negedge clk);
        bid_v[0] = b0; bid_v[1] = b1; bid_v[2] = b2; bid_v[3] = b3;
        bank_bal[0] = a0; bank_bal[1] = a1; bank_bal[2] = a2; bank_bal[3] = a3;
    endtask

    // rel_at/drop_at/frel_at: grant cycle (1 = charge cycle) in which the event is driven; 0 = never.
    task automatic transaction(input string tag, input logic [N-1:0] r,
                               input int rel_at, input int frel_at, input int drop_at);
        int w, exp_w, width, exp_bal;
        logic [N-1:0] oh;
`ifdef BID_ARB_RR_EN
        w = pick(r, rr_exp);
`else
        w = pick(r, 0);
`endif
        exp_w = TENURE;
        if (rel_at > 0 && rel_at < exp_w) exp_w = rel_at;
        if (drop_at > 0 && drop_at < exp_w) exp_w = drop_at;
        @(negedge clk);
        req = r;
        rel = '0;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
        end
        chk({tag, ".pre_gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        if (w < 0) begin
            chk({tag, ".nobid"}, 32'(nobid), 32'd1);
            chk({tag, ".nogrant"}, 32'(gnt), 32'd0);
            @(negedge clk);
            req = '0;
            @(posedge clk); #1;
            chk({tag, ".nobid_pulse"}, 32'(nobid), 32'd0);
            chk({tag, ".nogrant2"}, 32'(gnt | charge), 32'd0);
        end else begin
            oh = N'(1) << w;
            exp_charges++;
            exp_bal = bank_bal[w] - bid_v[w];
            chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
            chk({tag, ".charge"}, 32'(charge), 32'(oh));
            chk({tag, ".win_bid"}, 32'(win_bid), 32'(bid_v[w]));
            width = 1;
            for (int k = 1; k <= TENURE + 2; k++) begin
                @(negedge clk);
                rel = '0;
                if (k == rel_at) rel[w] = 1'b1;
                if (k == frel_at) rel[(w + 1) % N] = 1'b1;
                if (k == drop_at) req[w] = 1'b0;
                @(posedge clk); #1;
                if (k == 1) chk({tag, ".charge_once"}, 32'(charge), 32'd0);
                if (gnt == oh) width++;
                else break;
            end
            chk({tag, ".width"}, 32'(width), 32'(exp_w));
            chk({tag, ".gnt_off"}, 32'(gnt), 32'd0);
            chk({tag, ".bank"}, 32'(bank_bal[w]), 32'(exp_bal));
            @(negedge clk);
            req = '0;
            rel = '0;
`ifdef BID_ARB_RR_EN
            rr_exp = (w + 1) % N;
`endif
        end
        @(posedge clk); #1;
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int bal_before;
        logic [N-1:0] r;
        int ra;
        clk = 1'b0;
        rst = 1'b1;
        req = '0;
        rel = '0;
        for (int i = 0; i < N; i++) begin
            bid_v[i]    = 0;
            bank_bal[i] = 750;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset.gnt", 32'(gnt), 32'd0);
        chk("reset.charge", 32'(charge), 32'd0);
        chk("reset.win_bid", 32'(win_bid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.nobid", 32'(nobid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        set_all(5, 0, 0, 0, 750, 750, 750, 750);
        transaction("single", 4'b0001, 0, 0, 0);
        set_all(3, 9, 7, 2, 750, 750, 750, 750);
        transaction("highest", 4'b1111, 0, 0, 0);
        set_all(0, 9, 7, 0, 750, 9, 750, 750);
        transaction("unaffordable", 4'b1111, 0, 0, 0);
        set_all(0, 0, 0, 0, 750, 750, 750, 750);
        transaction("allzero", 4'b1111, 0, 0, 0);
        set_all(5, 6, 7, 8, 5, 3, 7, 1);
        transaction("allbroke", 4'b1111, 0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            set_all(4, 4, 4, 4, 750, 750, 750, 750);
            transaction($sformatf("tie%0d", t), 4'b1111, 0, 0, 0);
        end
        set_all(2, 8, 3, 1, 750, 750, 750, 750);
        transaction("early_rel", 4'b1111, 4, 0, 0);
        set_all(2, 8, 3, 1, 750, 750, 750, 750);
        transaction("foreign_rel", 4'b1111, 0, 3, 0);
        set_all(2, 8, 3, 1, 750, 750, 750, 750);
        transaction("drop_req", 4'b1111, 0, 0, 5);
        set_all(7, 7, 7, 7, 750, 750, 750, 750);
        transaction("rel_at_expiry", 4'b1111, TENURE, 0, 0);

        // Reset in the middle of a hold.
        set_all(6, 0, 0, 0, 100, 750, 750, 750);
        bal_before = bank_bal[0];
        @(negedge clk);
        req = 4'b0001;
        repeat (N + 2 + 4) @(posedge clk);
        #1;
        chk("rst_mid.gnt_before", 32'(gnt), 32'd1);
        exp_charges++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        chk("rst_mid.gnt_async", 32'(gnt), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rr_exp = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.charge", 32'(charge), 32'd0);
        chk("rst_mid.bank", 32'(bank_bal[0]), 32'(bal_before - 6));

        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                bid_v[i]    = int'($urandom_range(0, 15));
                bank_bal[i] = int'($urandom_range(1, 40));
            end
            r  = N'($urandom_range(1, (1 << N) - 1));
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, TENURE)) : 0;
            transaction($sformatf("rand%0d", t), r, ra, 0, 0);
        end

        chk("charge_total", 32'(charges), 32'(exp_charges));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
